// File: rtl/cmd_pkg.sv
// Shared definitions for the command receive path: opcodes, frame assembler states, default baud divisor.
package cmd_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    // 50 MHz / 19200 baud
    localparam int DEF_BAUD_DIV = 2604;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_CMD = 2'd1,
        GOT_HI  = 2'd2
    } frm_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop RX synchroniser, mid-bit sampling, one-clk rx_rdy / rx_err pulses.
// rx_data is valid while rx_rdy is high; a start bit that reads high at mid-bit is treated as a glitch.
module uart_byte_rx
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam int BW = $clog2(BAUD_DIV);

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          busy_q;
    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [7:0]    shift_q;
    logic          rx_rdy_q, rx_err_q;

    // bit_q: 0 = start bit, 1..8 = data bits LSB first, 9 = stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            busy_q    <= 1'b0;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_rdy_q  <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_rdy_q  <= 1'b0;
            rx_err_q  <= 1'b0;
            if (!busy_q) begin
                if (rx_prev_q && !rx_s2_q) begin
                    busy_q <= 1'b1;
                    baud_q <= BW'(BAUD_DIV / 2);
                    bit_q  <= 4'd0;
                end
            end else if (baud_q != '0) begin
                baud_q <= baud_q - 1'b1;
            end else begin
                baud_q <= BW'(BAUD_DIV - 1);
                if (bit_q == 4'd0) begin
                    if (rx_s2_q) begin
                        busy_q <= 1'b0;
                    end else begin
                        bit_q <= 4'd1;
                    end
                end else if (bit_q <= 4'd8) begin
                    shift_q <= {rx_s2_q, shift_q[7:1]};
                    bit_q   <= bit_q + 4'd1;
                end else begin
                    busy_q   <= 1'b0;
                    rx_rdy_q <= rx_s2_q;
                    rx_err_q <= !rx_s2_q;
                end
            end
        end
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_err  = rx_err_q;
    assign rx_data = shift_q;

endmodule

// File: rtl/cmd_frame_rcv.sv
// Assembles 3-byte command frames (opcode, data hi, data lo) from the UART byte stream.
// Partial frames are abandoned on a stop-bit error or an over-long inter-byte gap, pulsing frm_err.
module cmd_frame_rcv
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV,
    parameter int GAP_TO   = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frm_err
);

    localparam int GW = $clog2(GAP_TO);

    logic       rx_rdy, rx_err;
    logic [7:0] rx_data;

    frm_state_e  state_q;
    logic [GW-1:0] gap_q;
    logic [7:0]  shadow_cmd_q, shadow_hi_q;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        cmd_rdy_q, frm_err_q;

    uart_byte_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rx_err  (rx_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            shadow_cmd_q <= '0;
            shadow_hi_q  <= '0;
            cmd_q        <= '0;
            data_q       <= '0;
            cmd_rdy_q    <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            frm_err_q <= 1'b0;
            if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            if (rx_rdy) begin
                // a byte arriving always beats a coincident timeout
                gap_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        shadow_cmd_q <= rx_data;
                        cmd_rdy_q    <= 1'b0;
                        state_q      <= GOT_CMD;
                    end
                    GOT_CMD: begin
                        shadow_hi_q <= rx_data;
                        state_q     <= GOT_HI;
                    end
                    GOT_HI: begin
                        cmd_q     <= shadow_cmd_q;
                        data_q    <= {shadow_hi_q, rx_data};
                        cmd_rdy_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (rx_err) begin
                frm_err_q <= 1'b1;
                gap_q     <= '0;
                state_q   <= IDLE;
            end else if (state_q != IDLE) begin
                if (gap_q == GW'(GAP_TO - 1)) begin
                    frm_err_q <= 1'b1;
                    gap_q     <= '0;
                    state_q   <= IDLE;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
            end
        end
    end

    assign cmd_rdy = cmd_rdy_q;
    assign cmd     = cmd_q;
    assign data    = data_q;
    assign frm_err = frm_err_q;

endmodule
